// File: rtl/roi_pkg.sv
// ---------------------------------------------------------------------------
// roi_pkg
// Shared definitions for the ROI APB register slice. This package holds the
// register map offsets, the CTRL/STATUS bit positions, the APB FSM state
// enum, the packed corner type, and the decoded-access record that the APB
// front end passes to the register banks.
// ---------------------------------------------------------------------------
package roi_pkg;

    // Widest coordinate supported. Corners are stored in fields of this
    // width, and any bits above COORD_W are kept at zero.
    localparam int unsigned COORD_MAX_W        = 16;
    localparam int unsigned CORNER_X_LSB       = 0;
    localparam int unsigned CORNER_Y_LSB       = 16;

    // Register map
    localparam int unsigned ROI_STRIDE         = 8;       // bytes per region
    localparam int unsigned CORNER1_OFS        = 4;       // corner1 offset inside a region
    localparam int unsigned ADDR_CTRL          = 'h100;
    localparam int unsigned ADDR_STATUS        = 'h104;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_COMMIT_BIT    = 0;
    localparam int unsigned CTRL_ENABLE_LSB    = 8;
    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_ENABLE_LSB  = 8;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] y;
        logic [COORD_MAX_W-1:0] x;
    } corner_t;

    // Decoded view of the current APB address
    typedef struct packed {
        logic       corner;   // hits a corner register of an existing region
        logic       c1;       // corner1 (else corner0)
        logic [3:0] roi;      // region index
        logic       ctrl;     // CTRL register
        logic       status;   // STATUS register
    } apb_dec_t;

endpackage

// File: rtl/roi_apb_if.sv
// ---------------------------------------------------------------------------
// roi_apb_if
// APB slave front end for roi_apb_multi. It runs the IDLE/SETUP/ACCESS FSM
// with zero wait states in ACCESS, decodes the address, produces the
// write strobe for the register banks, and registers read data on the
// SETUP->ACCESS edge.
//
// Ports
//   clk_i, arst_i        clock, async active-high reset
//   apb_paddr_i          byte address
//   apb_pwrite_i         write/read select
//   apb_psel_i           APB select
//   apb_penable_i        APB enable
//   apb_prdata_o         registered read data, non-zero only in ACCESS
//   apb_pready_o         ready, high in ACCESS
//   dec_o                combinational decode of apb_paddr_i
//   wr_en_o              write commit strobe (ACCESS & psel & penable & pwrite)
//   rd_data_i            read mux value from the register banks
//   apb_pslverr_o        error response (only with ROI_APB_PSLVERR_EN)
//
// Configuration macro: ROI_APB_PSLVERR_EN
// ---------------------------------------------------------------------------
module roi_apb_if
    import roi_pkg::*;
#(
    parameter int unsigned APB_DATA_W = 32,
    parameter int unsigned APB_ADDR_W = 12,
    parameter int unsigned ROI_NUM    = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [APB_ADDR_W-1:0] apb_paddr_i,
    input  logic                  apb_pwrite_i,
    input  logic                  apb_psel_i,
    input  logic                  apb_penable_i,
    output logic [APB_DATA_W-1:0] apb_prdata_o,
    output logic                  apb_pready_o,
    output apb_dec_t              dec_o,
    output logic                  wr_en_o,
    input  logic [APB_DATA_W-1:0] rd_data_i
`ifdef ROI_APB_PSLVERR_EN
    ,
    output logic                  apb_pslverr_o
`endif
);

    apb_state_t            state_q;
    apb_state_t            state_d;
    logic [APB_DATA_W-1:0] prdata_q;
    logic                  mapped;

    // Address decode
    always_comb begin
        dec_o        = '0;
        dec_o.corner = (apb_paddr_i < APB_ADDR_W'(ROI_STRIDE * ROI_NUM)) &&
                       (apb_paddr_i[1:0] == 2'b00);
        dec_o.c1     = apb_paddr_i[$clog2(CORNER1_OFS)];
        dec_o.roi    = apb_paddr_i[$clog2(ROI_STRIDE) +: 4];
        dec_o.ctrl   = (apb_paddr_i == APB_ADDR_W'(ADDR_CTRL));
        dec_o.status = (apb_paddr_i == APB_ADDR_W'(ADDR_STATUS));
    end

    assign mapped = dec_o.corner | dec_o.ctrl | dec_o.status;

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= APB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    state_d = APB_SETUP;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (apb_psel_i && !apb_penable_i) begin
                    state_d = APB_SETUP;
                end else begin
                    state_d = APB_IDLE;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        apb_pready_o  = 1'b0;
        wr_en_o       = 1'b0;
`ifdef ROI_APB_PSLVERR_EN
        apb_pslverr_o = 1'b0;
`endif
        if (state_q == APB_ACCESS) begin
            apb_pready_o  = 1'b1;
            wr_en_o       = apb_psel_i & apb_penable_i & apb_pwrite_i;
`ifdef ROI_APB_PSLVERR_EN
            apb_pslverr_o = !mapped || (dec_o.status && apb_pwrite_i);
`endif
        end
    end

    // Read data is captured on the SETUP->ACCESS edge and cleared on every
    // other edge, so it is visible only for the ACCESS cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            prdata_q <= '0;
        end else if (state_q == APB_SETUP && !apb_pwrite_i && mapped) begin
            prdata_q <= rd_data_i;
        end else begin
            prdata_q <= '0;
        end
    end

    assign apb_prdata_o = prdata_q;

endmodule

// File: rtl/roi_apb_multi.sv
// ---------------------------------------------------------------------------
// roi_apb_multi
// Multi-region ROI register block with an APB slave. Corner and enable
// writes land in a shadow set. A COMMIT write arms a copy, and the next
// frame_start_i moves the shadow set into the active set that drives the
// outputs.
//
// Ports
//   clk_i, arst_i            clock, async active-high reset
//   apb_paddr_i              APB byte address
//   apb_pwdata_i             APB write data
//   apb_pwrite_i             APB write select
//   apb_psel_i               APB select
//   apb_penable_i            APB enable
//   apb_prdata_o             APB read data
//   apb_pready_o             APB ready
//   frame_start_i            one-cycle frame sync
//   roi_xy0_o / roi_xy1_o    active corners per region, {Y[16+:COORD_W], X[0+:COORD_W]}
//   roi_valid_o              region enabled and well-formed (registered)
//   commit_done_o            one-cycle pulse after a shadow->active copy
//   apb_pslverr_o            APB error (only with ROI_APB_PSLVERR_EN)
//
// Configuration macro: ROI_APB_PSLVERR_EN
// ---------------------------------------------------------------------------
module roi_apb_multi
    import roi_pkg::*;
#(
    parameter int unsigned APB_DATA_W = 32,
    parameter int unsigned APB_ADDR_W = 12,
    parameter int unsigned ROI_NUM    = 4,
    parameter int unsigned COORD_W    = 10
) (
    input  logic                               clk_i,
    input  logic                               arst_i,
    input  logic [APB_ADDR_W-1:0]              apb_paddr_i,
    input  logic [APB_DATA_W-1:0]              apb_pwdata_i,
    input  logic                               apb_pwrite_i,
    input  logic                               apb_psel_i,
    input  logic                               apb_penable_i,
    output logic [APB_DATA_W-1:0]              apb_prdata_o,
    output logic                               apb_pready_o,
    input  logic                               frame_start_i,
    output logic [ROI_NUM-1:0][APB_DATA_W-1:0] roi_xy0_o,
    output logic [ROI_NUM-1:0][APB_DATA_W-1:0] roi_xy1_o,
    output logic [ROI_NUM-1:0]                 roi_valid_o,
    output logic                               commit_done_o
`ifdef ROI_APB_PSLVERR_EN
    ,
    output logic                               apb_pslverr_o
`endif
);

    apb_dec_t                  dec;
    logic                      wr_en;
    logic [APB_DATA_W-1:0]     rd_data;
    logic                      commit_wr;
    logic                      copy;
    logic                      unused_wdata;

    corner_t [ROI_NUM-1:0]     sh_c0_q;
    corner_t [ROI_NUM-1:0]     sh_c1_q;
    corner_t [ROI_NUM-1:0]     act_c0_q;
    corner_t [ROI_NUM-1:0]     act_c1_q;
    logic    [ROI_NUM-1:0]     sh_en_q;
    logic    [ROI_NUM-1:0]     act_en_q;
    logic    [ROI_NUM-1:0]     valid_d;
    logic    [ROI_NUM-1:0]     valid_q;
    logic                      pending_q;
    logic                      done_q;

    // Only the coordinate fields survive a write. Everything else is dropped.
    function automatic corner_t to_corner(input logic [APB_DATA_W-1:0] w);
        corner_t c;
        c   = '0;
        c.x = COORD_MAX_W'(w[CORNER_X_LSB +: COORD_W]);
        c.y = COORD_MAX_W'(w[CORNER_Y_LSB +: COORD_W]);
        return c;
    endfunction

    function automatic logic [APB_DATA_W-1:0] from_corner(input corner_t c);
        logic [APB_DATA_W-1:0] w;
        w = '0;
        w[CORNER_X_LSB +: COORD_MAX_W] = c.x;
        w[CORNER_Y_LSB +: COORD_MAX_W] = c.y;
        return w;
    endfunction

    roi_apb_if #(
        .APB_DATA_W (APB_DATA_W),
        .APB_ADDR_W (APB_ADDR_W),
        .ROI_NUM    (ROI_NUM)
    ) u_apb_if (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .apb_paddr_i   (apb_paddr_i),
        .apb_pwrite_i  (apb_pwrite_i),
        .apb_psel_i    (apb_psel_i),
        .apb_penable_i (apb_penable_i),
        .apb_prdata_o  (apb_prdata_o),
        .apb_pready_o  (apb_pready_o),
        .dec_o         (dec),
        .wr_en_o       (wr_en),
        .rd_data_i     (rd_data)
`ifdef ROI_APB_PSLVERR_EN
        ,
        .apb_pslverr_o (apb_pslverr_o)
`endif
    );

    assign unused_wdata = ^apb_pwdata_i;

    assign commit_wr = wr_en & dec.ctrl & apb_pwdata_i[CTRL_COMMIT_BIT];
    assign copy      = frame_start_i & pending_q;

    // Shadow register set (APB writes only)
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sh_c0_q <= '0;
            sh_c1_q <= '0;
            sh_en_q <= '0;
        end else if (wr_en) begin
            if (dec.ctrl) begin
                sh_en_q <= apb_pwdata_i[CTRL_ENABLE_LSB +: ROI_NUM];
            end
            for (int unsigned n = 0; n < ROI_NUM; n++) begin
                if (dec.corner && dec.roi == 4'(n)) begin
                    if (dec.c1) begin
                        sh_c1_q[n] <= to_corner(apb_pwdata_i);
                    end else begin
                        sh_c0_q[n] <= to_corner(apb_pwdata_i);
                    end
                end
            end
        end
    end

    // Active register set. A copy in the same edge as a shadow write takes
    // the pre-write shadow value because both are non-blocking.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            act_c0_q <= '0;
            act_c1_q <= '0;
            act_en_q <= '0;
        end else if (copy) begin
            act_c0_q <= sh_c0_q;
            act_c1_q <= sh_c1_q;
            act_en_q <= sh_en_q;
        end
    end

    // Commit handshake. A COMMIT write always (re)arms PENDING, even when it
    // coincides with a frame start, so that copy waits for the next frame.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= '0;
        end else begin
            pending_q <= commit_wr | (pending_q & ~frame_start_i);
            done_q    <= copy;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        valid_d = '0;
        for (int unsigned n = 0; n < ROI_NUM; n++) begin
            valid_d[n] = act_en_q[n] &&
                         (act_c0_q[n].x <= act_c1_q[n].x) &&
                         (act_c0_q[n].y <= act_c1_q[n].y);
        end
    end

    // Read mux (shadow corners, shadow ENABLE in CTRL, active ENABLE in STATUS)
    always_comb begin
        rd_data = '0;
        if (dec.ctrl) begin
            rd_data[CTRL_ENABLE_LSB +: ROI_NUM] = sh_en_q;
        end else if (dec.status) begin
            rd_data[STATUS_PENDING_BIT]           = pending_q;
            rd_data[STATUS_ENABLE_LSB +: ROI_NUM] = act_en_q;
        end else if (dec.corner) begin
            for (int unsigned n = 0; n < ROI_NUM; n++) begin
                if (dec.roi == 4'(n)) begin
                    rd_data = from_corner(dec.c1 ? sh_c1_q[n] : sh_c0_q[n]);
                end
            end
        end
    end

    always_comb begin
        roi_xy0_o = '0;
        roi_xy1_o = '0;
        for (int unsigned n = 0; n < ROI_NUM; n++) begin
            roi_xy0_o[n] = from_corner(act_c0_q[n]);
            roi_xy1_o[n] = from_corner(act_c1_q[n]);
        end
    end

    assign roi_valid_o   = valid_q;
    assign commit_done_o = done_q;

endmodule

// File: tb/tb_roi_apb_multi.sv
// ---------------------------------------------------------------------------
// tb_roi_apb_multi
// Self-checking bench for roi_apb_multi (default parameters). It has a
// reference model of the register map (shadow/active sets, PENDING), a
// vector table, hand-written corner sequences and a randomized phase.
// ---------------------------------------------------------------------------
module tb_roi_apb_multi;

    localparam int unsigned NR    = 4;
    localparam logic [31:0] WMASK = 32'h03FF_03FF;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [11:0]     paddr = '0;
    logic [31:0]     pwdata = '0;
    logic            pwrite = 1'b0;
    logic            psel = 1'b0;
    logic            penable = 1'b0;
    logic [31:0]     prdata;
    logic            pready;
    logic            frame = 1'b0;
    logic [NR-1:0][31:0] roi_xy0;
    logic [NR-1:0][31:0] roi_xy1;
    logic [NR-1:0]   roi_valid;
    logic            commit_done;
`ifdef ROI_APB_PSLVERR_EN
    logic            pslverr;
`endif

    int checks = 0;
    int failures = 0;
    int cd_count = 0;
    int exp_pulses = 0;

    always #5 clk = ~clk;

    roi_apb_multi #(
        .APB_DATA_W (32),
        .APB_ADDR_W (12),
        .ROI_NUM    (NR),
        .COORD_W    (10)
    ) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .apb_paddr_i   (paddr),
        .apb_pwdata_i  (pwdata),
        .apb_pwrite_i  (pwrite),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .frame_start_i (frame),
        .roi_xy0_o     (roi_xy0),
        .roi_xy1_o     (roi_xy1),
        .roi_valid_o   (roi_valid),
        .commit_done_o (commit_done)
`ifdef ROI_APB_PSLVERR_EN
        ,
        .apb_pslverr_o (pslverr)
`endif
    );

    always @(negedge clk) if (commit_done === 1'b1) cd_count++;

    // ---------------- reference model ----------------
    logic [31:0]   m_sh0 [NR];
    logic [31:0]   m_sh1 [NR];
    logic [31:0]   m_act0[NR];
    logic [31:0]   m_act1[NR];
    logic [NR-1:0] m_sh_en;
    logic [NR-1:0] m_act_en;
    logic          m_pending;

    task automatic model_reset();
        for (int n = 0; n < NR; n++) begin
            m_sh0[n] = '0; m_sh1[n] = '0; m_act0[n] = '0; m_act1[n] = '0;
        end
        m_sh_en = '0; m_act_en = '0; m_pending = 1'b0;
    endtask

    function automatic bit is_corner(input logic [11:0] a);
        return (a % 4 == 0) && (int'(a) < 8 * NR);
    endfunction

    function automatic bit is_mapped(input logic [11:0] a);
        return is_corner(a) || a == 12'h100 || a == 12'h104;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        n = int'(a) / 8;
        if (is_corner(a)) begin
            if (a % 8 == 4) m_sh1[n] = d & WMASK;
            else            m_sh0[n] = d & WMASK;
        end else if (a == 12'h100) begin
            m_sh_en = NR'(d >> 8);
            if (d % 2 == 1) m_pending = 1'b1;
        end
    endtask

    task automatic model_frame();
        if (m_pending) begin
            for (int n = 0; n < NR; n++) begin
                m_act0[n] = m_sh0[n];
                m_act1[n] = m_sh1[n];
            end
            m_act_en   = m_sh_en;
            m_pending  = 1'b0;
            exp_pulses = exp_pulses + 1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int n;
        n = int'(a) / 8;
        if (is_corner(a)) return (a % 8 == 4) ? m_sh1[n] : m_sh0[n];
        if (a == 12'h100) return 32'(m_sh_en) << 8;
        if (a == 12'h104) return (32'(m_act_en) << 8) | 32'(m_pending);
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_valid(input int n);
        logic [31:0] x0, x1, y0, y1;
        x0 = m_act0[n] & 32'h3FF; y0 = m_act0[n] >> 16;
        x1 = m_act1[n] & 32'h3FF; y1 = m_act1[n] >> 16;
        return (m_act_en[n] && x0 <= x1 && y0 <= y1) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic [11:0] a, input logic [31:0] d, input logic wr,
                        input logic with_frame, output logic [31:0] rd, output logic err);
        bit got;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwdata = d; pwrite = wr;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pready === 1'b1) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL apb_pready_timeout: actual=0 required=1 addr=0x%03h", a);
        end
        rd = prdata;
`ifdef ROI_APB_PSLVERR_EN
        err = pslverr;
`else
        err = 1'b0;
`endif
        if (with_frame) begin
            frame = 1'b1;
            model_frame();
        end
        if (wr) model_write(a, d);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; frame = 1'b0;
    endtask

    task automatic wr32(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd; logic err;
        xfer(a, d, 1'b1, 1'b0, rd, err);
    endtask

    task automatic rd32(input logic [11:0] a, output logic [31:0] rd);
        logic err;
        xfer(a, 32'h0, 1'b0, 1'b0, rd, err);
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1;
        frame = 1'b1;
        model_frame();
        @(posedge clk); #1;
        frame = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < NR; n++) begin
            chk($sformatf("%s_xy0[%0d]", tag, n), roi_xy0[n], m_act0[n]);
            chk($sformatf("%s_xy1[%0d]", tag, n), roi_xy1[n], m_act1[n]);
            chk($sformatf("%s_valid[%0d]", tag, n), 32'(roi_valid[n]), model_valid(n));
        end
        chk($sformatf("%s_commit_pulses", tag), 32'(cd_count), 32'(exp_pulses));
    endtask

    function automatic logic [11:0] pick_addr();
        int unsigned s;
        s = $urandom_range(0, 12);
        if (s < 8)   return 12'(s * 4);
        if (s == 8)  return 12'h100;
        if (s == 9)  return 12'h104;
        if (s == 10) return 12'h200;
        if (s == 11) return 12'h020;
        return 12'h102;
    endfunction

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] exp;

        vt[0] = '{12'h008, 32'hFFFF_FFFF, 32'h03FF_03FF};
        vt[1] = '{12'h00C, 32'h1234_5678, 32'h0234_0278};
        vt[2] = '{12'h018, 32'hFC00_FC00, 32'h0000_0000};
        vt[3] = '{12'h01C, 32'h0001_03FF, 32'h0001_03FF};
        vt[4] = '{12'h200, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[5] = '{12'h020, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[6] = '{12'h104, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[7] = '{12'h100, 32'h0000_0A00, 32'h0000_0A00};

        // ---- reset state ----
        model_reset();
        @(posedge clk); #1;
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_commit_done", 32'(commit_done), 32'h0);
        chk("rst_valid", 32'(roi_valid), 32'h0);
        chk("rst_xy0_0", roi_xy0[0], 32'h0);
        chk("rst_xy1_3", roi_xy1[3], 32'h0);
        @(posedge clk); #1;
        arst = 1'b0;

        // ---- corner writes without COMMIT ----
        wr32(12'h000, 32'h0064_0064);
        wr32(12'h004, 32'h00C8_00C8);
        pulse_frame();
        check_outputs("nocommit");
        rd32(12'h104, rd);
        chk("nocommit_status", rd, 32'h0);

        // ---- basic commit ----
        wr32(12'h000, 32'h00C8_00C8);
        wr32(12'h004, 32'h0190_0190);
        wr32(12'h100, 32'h0000_0101);
        rd32(12'h104, rd);
        chk("status_pending", rd, 32'h0000_0001);
        chk("prdata_idle", prdata, 32'h0);
        pulse_frame();
        chk("commit_done_high", 32'(commit_done), 32'h1);
        @(posedge clk); #1;
        chk("commit_done_low", 32'(commit_done), 32'h0);
        chk("basic_xy0_0", roi_xy0[0], 32'h00C8_00C8);
        chk("basic_xy1_0", roi_xy1[0], 32'h0190_0190);
        chk("basic_valid_0", 32'(roi_valid[0]), 32'h1);
        check_outputs("basic");
        rd32(12'h104, rd);
        chk("status_after_copy", rd, 32'h0000_0100);

        // ---- inverted region is not valid ----
        wr32(12'h008, 32'h0190_00C8);
        wr32(12'h00C, 32'h00C8_0190);
        wr32(12'h100, 32'h0000_0301);
        pulse_frame();
        check_outputs("inverted");
        chk("inverted_valid_1", 32'(roi_valid[1]), 32'h0);

        // ---- COMMIT coincident with frame_start: copy deferred ----
        wr32(12'h010, 32'h0001_0001);
        wr32(12'h014, 32'h0002_0002);
        xfer(12'h100, 32'h0000_0701, 1'b1, 1'b1, rd, err);
        check_outputs("coincident");
        chk("coincident_xy0_2", roi_xy0[2], 32'h0);
        rd32(12'h104, rd);
        chk("coincident_status", rd, 32'h0000_0301);
        pulse_frame();
        check_outputs("deferred");
        chk("deferred_valid_2", 32'(roi_valid[2]), 32'h1);

        // ---- shadow write in the copy cycle ----
        wr32(12'h018, 32'h0010_0010);
        wr32(12'h01C, 32'h0020_0020);
        wr32(12'h100, 32'h0000_0F01);
        xfer(12'h018, 32'h0030_0030, 1'b1, 1'b1, rd, err);
        check_outputs("copywr");
        chk("copywr_act", roi_xy0[3], 32'h0010_0010);
        rd32(12'h018, rd);
        chk("copywr_shadow", rd, 32'h0030_0030);

        // ---- unmapped read ----
        xfer(12'h200, 32'h0, 1'b0, 1'b0, rd, err);
        chk("unmapped_rd", rd, 32'h0);
`ifdef ROI_APB_PSLVERR_EN
        chk("unmapped_pslverr", 32'(err), 32'h1);
`endif

        // ---- reset in the middle of a write ACCESS ----
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h010; pwdata = 32'h0007_0007; pwrite = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pready_before", 32'(pready), 32'h1);
        arst = 1'b1;
        #1;
        chk("midrst_pready", 32'(pready), 32'h0);
        chk("midrst_prdata", prdata, 32'h0);
        chk("midrst_valid", 32'(roi_valid), 32'h0);
        chk("midrst_commit_done", 32'(commit_done), 32'h0);
        for (int n = 0; n < NR; n++) begin
            chk($sformatf("midrst_xy0[%0d]", n), roi_xy0[n], 32'h0);
            chk($sformatf("midrst_xy1[%0d]", n), roi_xy1[n], 32'h0);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        arst = 1'b0;
        model_reset();
        rd32(12'h010, rd);
        chk("midrst_shadow", rd, 32'h0);

        // ---- vector table ----
        for (int i = 0; i < 8; i++) begin
            wr32(vt[i].addr, vt[i].wdata);
            rd32(vt[i].addr, rd);
            chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
        end

        // ---- randomized phase ----
        for (int k = 0; k < 250; k++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            a  = pick_addr();
            if (op < 4) begin
                d = $urandom;
                xfer(a, d, 1'b1, ($urandom_range(0, 4) == 0), rd, err);
`ifdef ROI_APB_PSLVERR_EN
                chk("rand_wr_pslverr", 32'(err), 32'(!is_mapped(a) || a == 12'h104));
`endif
            end else if (op < 8) begin
                exp = model_read(a);
                xfer(a, 32'h0, 1'b0, 1'b0, rd, err);
                chk($sformatf("rand_rd_%03h", a), rd, exp);
`ifdef ROI_APB_PSLVERR_EN
                chk("rand_rd_pslverr", 32'(err), 32'(!is_mapped(a)));
`endif
            end else begin
                pulse_frame();
                check_outputs("rand");
            end
        end
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
